cv32e40p_obi_stall_responder: RTL
=================================

// Module: cv32e40p_obi_stall_responder
// PURPOSE
// - OBI data-bus responder (memory side) for the core testbench: accepts core load/store requests,
//   backs them with a word-addressed RAM, returns in-order responses with programmable/random stalls.
// - Sits between the core data port and the bench; stresses the core LSU with gnt/rvalid back-pressure
//   and flags initiator-side OBI protocol violations.
// PARAMETERS
// - ADDR_WIDTH       16     byte-address bits decoded; RAM holds 2**(ADDR_WIDTH-2) 32-bit words
// - MAX_OUTSTANDING  2      response FIFO depth = max granted-but-unanswered transactions (>=1)
// - LFSR_SEED        8'hA5  reset value of the 8-bit stall LFSR (must be nonzero)
// PORTS
// - clk_i          in   1   clock
// - rst_ni         in   1   asynchronous active-low reset
// - req_i          in   1   OBI request
// - gnt_o          out  1   OBI grant (combinational from req_i and state)
// - addr_i         in   32  byte address; bits [ADDR_WIDTH-1:2] index RAM, rest ignored (wrap)
// - we_i           in   1   1 = store, 0 = load
// - be_i           in   4   byte enables
// - wdata_i        in   32  store data
// - rvalid_o       out  1   OBI response valid (one cycle per transaction, no rready)
// - rdata_o        out  32  load data; 0 for store responses
// - stall_en_i     in   1   enable random stalls
// - gnt_max_i      in   4   mask for random grant wait and random extra response delay
// - rvalid_lat_i   in   4   fixed extra response latency
// - err_o          out  1   sticky OBI protocol-violation flag
// BEHAVIOUR
// - Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, FIFO empty, wait counter 0, LFSR=LFSR_SEED.
//   RAM contents are not reset. Reset mid-operation discards all outstanding responses.
// - Grant: gnt_o = req_i & ~full & (gnt_wait==0). full blocks grant even if the head pops that cycle.
// - Accept (req_i & gnt_o): on a store, write wdata_i bytes selected by be_i in the same cycle. On a
//   load, read the RAM in the same cycle (sees all earlier stores). Push {rdata, cnt} into the FIFO.
//   Push cnt = rvalid_lat_i + (stall_en_i ? lfsr[7:4] & gnt_max_i : 0), 5-bit, no saturation needed.
//   On accept, load gnt_wait = stall_en_i ? lfsr[3:0] & gnt_max_i : 0; otherwise decrement while nonzero.
// - Response: every FIFO entry with cnt>0 decrements each cycle. rvalid_o=1 when the head is valid
//   and head cnt==0; head pops the same cycle. Responses are strictly in order; younger entries
//   at 0 wait behind the head. Earliest rvalid is the cycle after gnt; latency = 1 + cnt cycles.
// - rvalid_o/rdata_o are registered FIFO-head outputs; rdata_o is 0 when rvalid_o=0.
// - LFSR: 8-bit Galois, taps from package, advances every cycle while stall_en_i=1, else holds.
// - Protocol check: if req_i & ~gnt_o in cycle N, then in cycle N+1 req_i must still be 1 and
//   addr_i/we_i/be_i/wdata_i must equal cycle-N values; else err_o=1 from N+2, held until reset.
//   The responder keeps operating normally after an error.
// - Simultaneous push and pop when not full: both occur; occupancy unchanged.
// STRUCTURE
// - Package cv32e40p_obi_tb_pkg: resp_entry_t {logic [31:0] rdata; logic [4:0] cnt;},
//   LFSR_TAPS constant, OBI request struct obi_req_t {addr, we, be, wdata} used by the checker.
// - One sub-module: cv32e40p_obi_resp_fifo (depth MAX_OUTSTANDING, parallel per-entry countdown,
//   head_ready output). The RAM, grant-wait counter, LFSR and checker stay in the top module.
// TESTING
// - stall_en=0, lat=0: store 0xDEADBEEF @0x100 be=F, then load @0x100 -> each gnt in req cycle,
//   rvalid exactly 1 cycle after each gnt, load rdata=0xDEADBEEF, store rdata=0.
// - Store 0x11223344 @0x40, store 0x0000AA00 be=4'b0010 @0x40, load @0x40 -> rdata=0x1122AA44.
// - lat=3, MAX_OUTSTANDING=2, 3 back-to-back loads from c0 -> gnt c0,c1; rvalid c4,c5;
//   third gnt c5 (blocked c2..c4), its rvalid c9.
// - Protocol: gnt_max=15, stall_en=1, seed giving wait>0; change addr_i while req_i=1 and
//   gnt_o=0 -> err_o=1 two cycles after the stall cycle, stays 1 until rst_ni low.
// - Random: stall_en=1, gnt_max=15, lat=2, 1000 random loads/stores vs scoreboard -> all rdata match,
//   in order, no rvalid in gnt cycle, grant wait <=15, response latency <=18, err_o=0.
// - Reset with 2 outstanding -> rvalid_o=0 asynchronously, no stale rvalid after release,
//   RAM data written earlier still read back.

Source files
------------

// File: rtl/cv32e40p_obi_tb_pkg.sv
// Shared types and constants for the OBI stall responder.
package cv32e40p_obi_tb_pkg;

   // Right-shift Galois toggle mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length).
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // One granted transaction waiting for its response slot.
   typedef struct packed {
      logic [31:0] rdata;
      logic [4:0]  cnt;
   } resp_entry_t;

   // Initiator request fields that must stay stable while waiting for a grant.
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] state);
      return {1'b0, state[7:1]} ^ (state[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO; every waiting entry counts its extra delay down in parallel,
// and the head pops itself as soon as its count reaches zero.
module cv32e40p_obi_resp_fifo
   import cv32e40p_obi_tb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  resp_entry_t push_data_i,
   output logic        full_o,
   output logic        head_ready_o,
   output logic [31:0] head_rdata_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   resp_entry_t      entry_q [DEPTH];
   resp_entry_t      entry_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push;
   logic             pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o       = (count_q == CntW'(DEPTH));
   assign head_ready_o = valid_q[rd_ptr_q] && (entry_q[rd_ptr_q].cnt == 5'd0);
   assign head_rdata_o = head_ready_o ? entry_q[rd_ptr_q].rdata : 32'h0;
   assign pop          = head_ready_o;
   // Full blocks a push even when the head leaves in the same cycle.
   assign push         = push_i && !full_o;

   // Next state: parallel countdown, then pop head, then append new entry.
   always_comb begin
      entry_d  = entry_q;
      valid_d  = valid_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i].cnt != 5'd0)) begin
            entry_d[i].cnt = entry_q[i].cnt - 5'd1;
         end
      end
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = ptr_inc(rd_ptr_q);
      end
      if (push) begin
         entry_d[wr_ptr_q] = push_data_i;
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
   end

   // State register; reset empties the FIFO and drops any pending responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         valid_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         entry_q  <= entry_d;
         valid_q  <= valid_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cv32e40p_obi_stall_responder.sv
// Memory-side OBI responder: word RAM, random grant/response stalls, protocol checker.
module cv32e40p_obi_stall_responder
   import cv32e40p_obi_tb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   input  logic        stall_en_i,
   input  logic [3:0]  gnt_max_i,
   input  logic [3:0]  rvalid_lat_i,
   output logic        err_o
);

   localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);

   logic [31:0]           mem_q [Words];
   logic [ADDR_WIDTH-3:0] word_idx;
   logic                  unused_addr;

   logic                  fifo_full;
   logic                  accept;
   resp_entry_t           push_data;

   logic [3:0]            gnt_wait_q, gnt_wait_d;
   logic [7:0]            lfsr_q, lfsr_d;
   obi_req_t              cur_req;
   obi_req_t              prev_req_q;
   logic                  stall_q, stall_d;
   logic                  err_q, err_d;

   // Address bits above the RAM and the byte offset only wrap/alias.
   assign word_idx    = addr_i[ADDR_WIDTH-1:2];
   assign unused_addr = ^{addr_i[31:ADDR_WIDTH], addr_i[1:0]};

   assign gnt_o  = req_i && !fifo_full && (gnt_wait_q == 4'd0);
   assign accept = req_i && gnt_o;
   assign err_o  = err_q;

   assign cur_req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

   // Response entry: load data read this cycle (stores answer 0) plus extra delay.
   always_comb begin
      push_data       = '0;
      push_data.rdata = we_i ? 32'h0 : mem_q[word_idx];
      push_data.cnt   = {1'b0, rvalid_lat_i}
                      + (stall_en_i ? {1'b0, lfsr_q[7:4] & gnt_max_i} : 5'd0);
   end

   // Byte-enabled store on accept; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Next state for grant wait, LFSR and the request-stability checker.
   always_comb begin
      gnt_wait_d = gnt_wait_q;
      lfsr_d     = lfsr_q;
      stall_d    = req_i && !gnt_o;
      err_d      = err_q;
      if (accept) begin
         gnt_wait_d = stall_en_i ? (lfsr_q[3:0] & gnt_max_i) : 4'd0;
      end else if (gnt_wait_q != 4'd0) begin
         gnt_wait_d = gnt_wait_q - 4'd1;
      end
      if (stall_en_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
      // A stalled request must be repeated unchanged the following cycle.
      if (stall_q && (!req_i || (cur_req != prev_req_q))) begin
         err_d = 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_wait_q <= 4'd0;
         lfsr_q     <= LFSR_SEED;
         prev_req_q <= '0;
         stall_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         gnt_wait_q <= gnt_wait_d;
         lfsr_q     <= lfsr_d;
         prev_req_q <= cur_req;
         stall_q    <= stall_d;
         err_q      <= err_d;
      end
   end

   cv32e40p_obi_resp_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (accept),
      .push_data_i  (push_data),
      .full_o       (fifo_full),
      .head_ready_o (rvalid_o),
      .head_rdata_o (rdata_o)
   );

endmodule
